// File: rtl/wt_cache_pkg.sv
// -----------------------------------------------------------------------------
// wt_cache_pkg
// Shared types for the write-through dcache and its memory-side helpers.
//   dcache_req_t  : request from the dcache towards the memory adapter
//   dcache_rtrn_t : return from the memory adapter towards the dcache
//   DCACHE_MAX_TX : default cap on issued-but-unreturned dcache requests
//   is_counted_rtrn() : true for a valid return that retires a request
//                       (invalidations never retire anything)
// -----------------------------------------------------------------------------
package wt_cache_pkg;

    localparam int unsigned DCACHE_MAX_TX    = 4;
    localparam int unsigned DCACHE_TID_WIDTH = 2;
    localparam int unsigned DCACHE_WAY_WIDTH = 2;
    localparam int unsigned PADDR_WIDTH      = 32;
    localparam int unsigned XLEN             = 64;

    typedef enum logic [1:0] {
        DCACHE_LOAD_REQ   = 2'd0,
        DCACHE_STORE_REQ  = 2'd1,
        DCACHE_ATOMIC_REQ = 2'd2
    } dcache_out_t;

    typedef enum logic [1:0] {
        DCACHE_LOAD_ACK   = 2'd0,
        DCACHE_STORE_ACK  = 2'd1,
        DCACHE_INV_REQ    = 2'd2,
        DCACHE_ATOMIC_ACK = 2'd3
    } dcache_in_t;

    typedef enum logic [3:0] {
        AMO_NONE = 4'd0,
        AMO_LR   = 4'd1,
        AMO_SC   = 4'd2,
        AMO_SWAP = 4'd3,
        AMO_ADD  = 4'd4,
        AMO_AND  = 4'd5,
        AMO_OR   = 4'd6,
        AMO_XOR  = 4'd7,
        AMO_MAX  = 4'd8,
        AMO_MAXU = 4'd9,
        AMO_MIN  = 4'd10,
        AMO_MINU = 4'd11,
        AMO_CAS1 = 4'd12,
        AMO_CAS2 = 4'd13
    } amo_t;

    typedef struct packed {
        dcache_out_t                 rtype;
        logic [2:0]                  size;
        logic [DCACHE_WAY_WIDTH-1:0] way;
        logic [PADDR_WIDTH-1:0]      paddr;
        logic [XLEN-1:0]             data;
        logic                        nc;
        logic [DCACHE_TID_WIDTH-1:0] tid;
        amo_t                        amo_op;
    } dcache_req_t;

    typedef struct packed {
        dcache_in_t                  rtype;
        logic [XLEN-1:0]             data;
        logic [DCACHE_TID_WIDTH-1:0] tid;
    } dcache_rtrn_t;

    // A return retires an outstanding request unless it is an invalidation.
    function automatic logic is_counted_rtrn(input logic vld, input dcache_in_t rtype);
        return vld & (rtype != DCACHE_INV_REQ);
    endfunction

endpackage

// File: rtl/wt_dcache_req_buffer_chk.sv
// -----------------------------------------------------------------------------
// wt_dcache_req_buffer_chk
// Simulation-only protocol assertions for wt_dcache_req_buffer. Only built
// when WT_DCACHE_REQBUF_CHK_EN is defined.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   out_req, out_ack    : adapter-side handshake
//   out_data            : head payload presented to the adapter
//   push, full          : FIFO write strobe and full flag
//   out_cnt             : outstanding counter
// -----------------------------------------------------------------------------
`ifdef WT_DCACHE_REQBUF_CHK_EN
module wt_dcache_req_buffer_chk
    import wt_cache_pkg::*;
#(
    parameter int unsigned CntW           = 3,
    parameter int unsigned MaxOutstanding = 4
) (
    input logic            clk,
    input logic            rst_n,
    input logic            out_req,
    input logic            out_ack,
    input dcache_req_t     out_data,
    input logic            push,
    input logic            full,
    input logic [CntW-1:0] out_cnt
);

    // A presented but unaccepted head must not change under the adapter.
    a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_req && !out_ack) |=> (out_req && $stable(out_data)));

    // The dcache is never acked into a full FIFO.
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> !full);

    // Outstanding count never exceeds the cap.
    a_cnt_cap: assert property (@(posedge clk) disable iff (!rst_n)
        (32'(out_cnt) <= MaxOutstanding));

endmodule
`endif

// File: rtl/wt_dcache_req_fifo.sv
// -----------------------------------------------------------------------------
// wt_dcache_req_fifo
// Small request FIFO, synchronous active-low reset, power-of-two depth.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   push, wdata  : write request (ignored while full)
//   pop          : drop head entry (ignored while empty)
//   rdata        : head entry (meaningless while empty)
//   full, empty  : occupancy flags, derived from registered pointers only
// -----------------------------------------------------------------------------
module wt_dcache_req_fifo
    import wt_cache_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  dcache_req_t wdata,
    input  logic        pop,
    output dcache_req_t rdata,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = $clog2(Depth);

    logic [AW:0]  wptr_r;
    logic [AW:0]  rptr_r;
    dcache_req_t  mem_r [Depth];
    logic         push_ok_s;
    logic         pop_ok_s;

    assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign empty     = (wptr_r == rptr_r);
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rdata     = mem_r[rptr_r[AW-1:0]];

    // Pointer update; the wrap bit toggles naturally on overflow of the index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_r <= {(AW+1){1'b0}};
            rptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Payload storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/wt_dcache_req_buffer.sv
// -----------------------------------------------------------------------------
// wt_dcache_req_buffer
// Request buffer and outstanding-transaction tracker between the write-through
// dcache memory port and the memory adapter. Requests are queued in a small
// FIFO, issued to the adapter only while fewer than MaxOutstanding requests
// are unreturned, and returns pass straight back to the dcache.
// Optional feature macro: WT_DCACHE_REQBUF_CHK_EN (per-tid tracking, sticky
// err_o and simulation assertions). Without it err_o is constant 0.
// Ports:
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   dc_req_i/dc_ack_o        : dcache request handshake, dc_data_i payload
//   out_req_o/out_ack_i      : adapter handshake, out_data_o head payload
//   rtrn_vld_i/rtrn_i        : adapter return
//   dc_rtrn_vld_o/dc_rtrn_o  : return forwarded to the dcache
//   idle_o                   : nothing queued and nothing outstanding
//   err_o                    : sticky protocol error
// -----------------------------------------------------------------------------
module wt_dcache_req_buffer
    import wt_cache_pkg::*;
#(
    parameter int unsigned Depth          = 2,
    parameter int unsigned MaxOutstanding = DCACHE_MAX_TX
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         dc_req_i,
    output logic         dc_ack_o,
    input  dcache_req_t  dc_data_i,
    output logic         out_req_o,
    input  logic         out_ack_i,
    output dcache_req_t  out_data_o,
    input  logic         rtrn_vld_i,
    input  dcache_rtrn_t rtrn_i,
    output logic         dc_rtrn_vld_o,
    output dcache_rtrn_t dc_rtrn_o,
    output logic         idle_o,
    output logic         err_o
);

    localparam int unsigned     CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
    localparam logic [CntW-1:0] ZeroCnt = {CntW{1'b0}};
    localparam logic [CntW-1:0] OneCnt  = {{(CntW-1){1'b0}}, 1'b1};

    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;
    logic            rtrn_cnt_s;
    logic [CntW-1:0] out_cnt_r;

    // Push depends only on dc_req_i and registered FIFO state, so a pop in
    // the same cycle never frees a slot and out_ack_i cannot reach dc_ack_o.
    assign push_s     = dc_req_i & ~full_s;
    assign dc_ack_o   = push_s;
    assign out_req_o  = ~empty_s & (out_cnt_r < MaxCnt);
    assign pop_s      = out_req_o & out_ack_i;
    assign rtrn_cnt_s = is_counted_rtrn(rtrn_vld_i, rtrn_i.rtype);

    assign dc_rtrn_vld_o = rtrn_vld_i;
    assign dc_rtrn_o     = rtrn_i;
    assign idle_o        = empty_s & (out_cnt_r == ZeroCnt);

    wt_dcache_req_fifo #(
        .Depth (Depth)
    ) i_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push_s),
        .wdata (dc_data_i),
        .pop   (pop_s),
        .rdata (out_data_o),
        .full  (full_s),
        .empty (empty_s)
    );

    // Outstanding counter: +1 per issue, -1 per counted return, saturating at 0.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_cnt_r <= ZeroCnt;
        end else begin
            case ({pop_s, rtrn_cnt_s})
                2'b10: out_cnt_r <= out_cnt_r + OneCnt;
                2'b01: begin
                    if (out_cnt_r != ZeroCnt) begin
                        out_cnt_r <= out_cnt_r - OneCnt;
                    end else begin
                        out_cnt_r <= ZeroCnt;
                    end
                end
                default: out_cnt_r <= out_cnt_r;
            endcase
        end
    end

`ifdef WT_DCACHE_REQBUF_CHK_EN
    localparam int unsigned NumTid = 1 << DCACHE_TID_WIDTH;

    logic [CntW-1:0]   tid_cnt_r   [NumTid];
    logic [CntW-1:0]   tid_cnt_nxt_s [NumTid];
    logic [NumTid-1:0] inc_s;
    logic [NumTid-1:0] dec_s;
    logic [NumTid-1:0] dec_ok_s;
    logic              err_set_s;
    logic              err_r;

    // Per-tid bookkeeping. A return retires against the count held before
    // this cycle; an issue to a tid already at the cap is an overflow unless
    // the same tid retires in the same cycle.
    always_comb begin
        inc_s     = {NumTid{1'b0}};
        dec_s     = {NumTid{1'b0}};
        dec_ok_s  = {NumTid{1'b0}};
        err_set_s = 1'b0;
        for (int unsigned t = 0; t < NumTid; t++) begin
            tid_cnt_nxt_s[t] = tid_cnt_r[t];
            inc_s[t]    = pop_s & (out_data_o.tid == DCACHE_TID_WIDTH'(t));
            dec_s[t]    = rtrn_cnt_s & (rtrn_i.tid == DCACHE_TID_WIDTH'(t));
            dec_ok_s[t] = dec_s[t] & (tid_cnt_r[t] != ZeroCnt);
            err_set_s   = err_set_s
                        | (dec_s[t] & ~dec_ok_s[t])
                        | (inc_s[t] & ~dec_ok_s[t] & (tid_cnt_r[t] == MaxCnt));
            if (inc_s[t] && !dec_ok_s[t]) begin
                if (tid_cnt_r[t] != MaxCnt) begin
                    tid_cnt_nxt_s[t] = tid_cnt_r[t] + OneCnt;
                end else begin
                    tid_cnt_nxt_s[t] = tid_cnt_r[t];
                end
            end else if (!inc_s[t] && dec_ok_s[t]) begin
                tid_cnt_nxt_s[t] = tid_cnt_r[t] - OneCnt;
            end else begin
                tid_cnt_nxt_s[t] = tid_cnt_r[t];
            end
        end
    end

    // Per-tid counters and sticky error flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned t = 0; t < NumTid; t++) begin
                tid_cnt_r[t] <= ZeroCnt;
            end
            err_r <= 1'b0;
        end else begin
            for (int unsigned t = 0; t < NumTid; t++) begin
                tid_cnt_r[t] <= tid_cnt_nxt_s[t];
            end
            err_r <= err_r | err_set_s;
        end
    end

    assign err_o = err_r;

    wt_dcache_req_buffer_chk #(
        .CntW           (CntW),
        .MaxOutstanding (MaxOutstanding)
    ) i_chk (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .out_req  (out_req_o),
        .out_ack  (out_ack_i),
        .out_data (out_data_o),
        .push     (push_s),
        .full     (full_s),
        .out_cnt  (out_cnt_r)
    );
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wt_dcache_req_buffer.sv
// -----------------------------------------------------------------------------
// tb_wt_dcache_req_buffer
// Self-checking bench: a queue/counter model of the buffer is compared with
// the DUT every cycle, directed scenarios pin the model with literal values,
// then a randomized phase exercises mixed traffic and resets.
// -----------------------------------------------------------------------------
module tb_wt_dcache_req_buffer;
    import wt_cache_pkg::*;

    localparam int unsigned DEPTH   = 2;
    localparam int unsigned MAX_OUT = 2;
    localparam int unsigned NUM_TID = 1 << DCACHE_TID_WIDTH;
`ifdef WT_DCACHE_REQBUF_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         dc_req;
    dcache_req_t  dc_data;
    logic         out_ack;
    logic         rtrn_vld;
    dcache_rtrn_t rtrn;
    logic         dc_ack;
    logic         out_req;
    dcache_req_t  out_data;
    logic         dc_rtrn_vld;
    dcache_rtrn_t dc_rtrn;
    logic         idle;
    logic         err;

    always #5 clk = ~clk;

    wt_dcache_req_buffer #(
        .Depth          (DEPTH),
        .MaxOutstanding (MAX_OUT)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .dc_req_i      (dc_req),
        .dc_ack_o      (dc_ack),
        .dc_data_i     (dc_data),
        .out_req_o     (out_req),
        .out_ack_i     (out_ack),
        .out_data_o    (out_data),
        .rtrn_vld_i    (rtrn_vld),
        .rtrn_i        (rtrn),
        .dc_rtrn_vld_o (dc_rtrn_vld),
        .dc_rtrn_o     (dc_rtrn),
        .idle_o        (idle),
        .err_o         (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    dcache_req_t m_q[$];
    int          m_cnt;
    int          m_tcnt[NUM_TID];
    bit          m_err;
    bit          e_ack;
    bit          e_out_req;
    bit          e_idle;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        check(nm, 256'(act), 256'(exp));
    endtask

    function automatic dcache_req_t rand_req(input logic [1:0] tid);
        dcache_req_t r;
        r.rtype  = dcache_out_t'(2'($urandom_range(0, 2)));
        r.size   = 3'($urandom_range(0, 3));
        r.way    = 2'($urandom);
        r.paddr  = $urandom;
        r.data   = {$urandom, $urandom};
        r.nc     = 1'($urandom);
        r.tid    = tid;
        r.amo_op = amo_t'(4'($urandom_range(0, 13)));
        return r;
    endfunction

    function automatic dcache_rtrn_t mk_rtrn(input dcache_in_t t, input logic [1:0] tid);
        dcache_rtrn_t r;
        r.rtype = t;
        r.data  = {$urandom, $urandom};
        r.tid   = tid;
        return r;
    endfunction

    // Called with inputs already set; compares outputs 1 time unit later.
    task automatic eval_cycle();
        #1;
        e_ack     = dc_req && (m_q.size() < DEPTH);
        e_out_req = (m_q.size() != 0) && (m_cnt < MAX_OUT);
        e_idle    = (m_q.size() == 0) && (m_cnt == 0);
        if (rst_n) begin
            chk1("dc_ack", dc_ack, e_ack);
            chk1("out_req", out_req, e_out_req);
            if (e_out_req) check("out_data", 256'(out_data), 256'(m_q[0]));
            chk1("dc_rtrn_vld", dc_rtrn_vld, rtrn_vld);
            check("dc_rtrn", 256'(dc_rtrn), 256'(rtrn));
            chk1("idle", idle, e_idle);
            chk1("err", err, m_err);
        end
    endtask

    // Advance the model across the rising edge, then park on the falling edge.
    task automatic tick();
        bit pop;
        bit counted;
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_cnt = 0;
            foreach (m_tcnt[i]) m_tcnt[i] = 0;
            m_err = 1'b0;
        end else begin
            pop     = e_out_req && out_ack;
            counted = rtrn_vld && (rtrn.rtype != DCACHE_INV_REQ);
`ifdef WT_DCACHE_REQBUF_CHK_EN
            if (counted) begin
                if (m_tcnt[rtrn.tid] == 0) m_err = 1'b1;
                else m_tcnt[rtrn.tid]--;
            end
            if (pop) begin
                if (m_tcnt[m_q[0].tid] == MAX_OUT) m_err = 1'b1;
                else m_tcnt[m_q[0].tid]++;
            end
`endif
            if (pop && !counted) m_cnt++;
            else if (!pop && counted && m_cnt > 0) m_cnt--;
            if (pop) void'(m_q.pop_front());
            if (e_ack) m_q.push_back(dc_data);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        dc_req   = 1'b0;
        out_ack  = 1'b0;
        rtrn_vld = 1'b0;
        eval_cycle();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        dcache_req_t a;
        dcache_req_t b;
        rst_n    = 1'b0;
        dc_req   = 1'b0;
        dc_data  = '0;
        out_ack  = 1'b0;
        rtrn_vld = 1'b0;
        rtrn     = '0;
        @(negedge clk);

        // Reset values
        do_reset();
        eval_cycle();
        chk1("rst_idle", idle, 1'b1);
        chk1("rst_out_req", out_req, 1'b0);
        chk1("rst_dc_ack", dc_ack, 1'b0);
        chk1("rst_err", err, 1'b0);
        tick();

        // Single load, adapter acks immediately, return in cycle 4
        dc_req = 1'b1; dc_data = rand_req(2'd1); out_ack = 1'b1;
        eval_cycle(); chk1("s1_ack_c0", dc_ack, 1'b1); chk1("s1_no_bypass", out_req, 1'b0); tick();
        dc_req = 1'b0;
        eval_cycle(); chk1("s1_out_req_c1", out_req, 1'b1); tick();
        out_ack = 1'b0;
        eval_cycle(); tick();
        eval_cycle(); tick();
        rtrn_vld = 1'b1; rtrn = mk_rtrn(DCACHE_LOAD_ACK, 2'd1);
        eval_cycle(); chk1("s1_rtrn_c4", dc_rtrn_vld, 1'b1); chk1("s1_busy_c4", idle, 1'b0); tick();
        rtrn_vld = 1'b0;
        eval_cycle(); chk1("s1_idle_c5", idle, 1'b1); tick();

        // Full FIFO: third request waits; pop while full does not admit a push
        do_reset();
        a = rand_req(2'd1);
        b = rand_req(2'd1);
        dc_req = 1'b1; dc_data = a;
        eval_cycle(); chk1("s2_ack_a", dc_ack, 1'b1); tick();
        dc_data = b;
        eval_cycle(); chk1("s2_ack_b", dc_ack, 1'b1); tick();
        dc_data = rand_req(2'd1);
        eval_cycle(); chk1("s2_full_block", dc_ack, 1'b0); tick();
        out_ack = 1'b1;
        eval_cycle(); chk1("s2_pop_no_push", dc_ack, 1'b0);
        check("s2_head_a", 256'(out_data), 256'(a)); tick();
        out_ack = 1'b0;
        eval_cycle(); chk1("s2_push_after", dc_ack, 1'b1);
        check("s2_head_b", 256'(out_data), 256'(b)); tick();
        dc_req = 1'b0;

        // Outstanding cap of 2 with 3 requests and no returns
        do_reset();
        out_ack = 1'b1; dc_req = 1'b1; dc_data = rand_req(2'd1);
        eval_cycle(); tick();
        dc_data = rand_req(2'd1);
        eval_cycle(); chk1("s3_pop1", out_req, 1'b1); tick();
        dc_data = rand_req(2'd1);
        eval_cycle(); chk1("s3_pop2", out_req, 1'b1); tick();
        dc_req = 1'b0;
        eval_cycle(); chk1("s3_capped", out_req, 1'b0); tick();
        eval_cycle(); chk1("s3_capped2", out_req, 1'b0); tick();
        rtrn_vld = 1'b1; rtrn = mk_rtrn(DCACHE_LOAD_ACK, 2'd1);
        eval_cycle(); chk1("s3_still_capped", out_req, 1'b0); tick();
        rtrn_vld = 1'b0;
        eval_cycle(); chk1("s3_resume", out_req, 1'b1); tick();
        out_ack = 1'b0;

        // Invalidation is forwarded but not counted; pop + return keeps count
        do_reset();
        dc_req = 1'b1; dc_data = rand_req(2'd1); out_ack = 1'b1;
        eval_cycle(); tick();
        dc_req = 1'b0;
        eval_cycle(); tick();
        out_ack = 1'b0;
        rtrn_vld = 1'b1; rtrn = mk_rtrn(DCACHE_INV_REQ, 2'd1);
        eval_cycle(); chk1("s4_inv_fwd", dc_rtrn_vld, 1'b1); tick();
        rtrn_vld = 1'b0;
        eval_cycle(); chk1("s4_inv_idle", idle, 1'b0); tick();
        dc_req = 1'b1; dc_data = rand_req(2'd1);
        eval_cycle(); tick();
        dc_req = 1'b0; out_ack = 1'b1;
        rtrn_vld = 1'b1; rtrn = mk_rtrn(DCACHE_STORE_ACK, 2'd1);
        eval_cycle(); chk1("s4_pop_ret", out_req, 1'b1); tick();
        out_ack = 1'b0; rtrn_vld = 1'b0;
        eval_cycle(); chk1("s4_cnt_kept", idle, 1'b0); tick();
        rtrn_vld = 1'b1; rtrn = mk_rtrn(DCACHE_LOAD_ACK, 2'd1);
        eval_cycle(); tick();
        rtrn_vld = 1'b0;
        eval_cycle(); chk1("s4_drained", idle, 1'b1); tick();

        // Reset mid-stream with two entries queued
        do_reset();
        dc_req = 1'b1; dc_data = rand_req(2'd0);
        eval_cycle(); tick();
        dc_data = rand_req(2'd0);
        eval_cycle(); tick();
        dc_req = 1'b0;
        eval_cycle(); chk1("s5_busy", idle, 1'b0); tick();
        rst_n = 1'b0;
        eval_cycle(); tick();
        rst_n = 1'b1;
        eval_cycle(); chk1("s5_rst_idle", idle, 1'b1); chk1("s5_rst_req", out_req, 1'b0); tick();

        // Return for a tid that was never issued
        do_reset();
        rtrn_vld = 1'b1; rtrn = mk_rtrn(DCACHE_LOAD_ACK, 2'd3);
        eval_cycle(); tick();
        rtrn_vld = 1'b0;
        eval_cycle(); chk1("s6_err", err, ERR_EXP); tick();
        eval_cycle(); tick();
        eval_cycle(); chk1("s6_err_sticky", err, ERR_EXP); tick();
        do_reset();
        eval_cycle(); chk1("s6_err_clr", err, 1'b0); tick();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if (!dc_req && $urandom_range(0, 2) != 0) begin
                dc_req  = 1'b1;
                dc_data = rand_req(2'($urandom));
            end
            out_ack  = ($urandom_range(0, 3) != 0);
            rtrn_vld = ($urandom_range(0, 2) == 0);
            rtrn     = mk_rtrn(dcache_in_t'(2'($urandom_range(0, 3))), 2'($urandom));
            eval_cycle();
            tick();
            if (e_ack && rst_n) dc_req = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
